// File: rtl/sequence_generator.sv
// sequence_generator: serial pattern transmitter, MSB first, one bit per clk.
// A run sends repeat_cnt+1 frames of the latched pattern, separated by gap idle cycles.
// Optional feature macro: SEQGEN_ABORT_EN adds abort/aborted to cancel a run.
// The repeat-count port is named repeat_cnt because repeat is a reserved word.
module sequence_generator #(
    parameter int   PAT_W    = 4,
    parameter int   CNT_W    = 8,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
`ifdef SEQGEN_ABORT_EN
    input  logic             abort,
    output logic             aborted,
`endif
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic [CNT_W-1:0] gap,
    output logic             ready,
    output logic             out,
    output logic             out_valid,
    output logic             frame_start,
    output logic             done
);
    localparam int IDX_W = $clog2(PAT_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

    state_t             state_q, state_d;
    logic [PAT_W-1:0]   shift_q, shift_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic [CNT_W-1:0]   gap_q, gap_d;
    logic [CNT_W-1:0]   frames_q, frames_d;   // frames still to send after the current one
    logic [CNT_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
`ifdef SEQGEN_ABORT_EN
    logic               aborted_q, aborted_d;
`endif

    // State register; reset abandons any run in progress without a done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            pat_q     <= '0;
            gap_q     <= '0;
            frames_q  <= '0;
            gap_cnt_q <= '0;
            idx_q     <= '0;
`ifdef SEQGEN_ABORT_EN
            aborted_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            pat_q     <= pat_d;
            gap_q     <= gap_d;
            frames_q  <= frames_d;
            gap_cnt_q <= gap_cnt_d;
            idx_q     <= idx_d;
`ifdef SEQGEN_ABORT_EN
            aborted_q <= aborted_d;
`endif
        end
    end

    // Next-state: accept in IDLE, shift through frames, count out gaps
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        pat_d     = pat_q;
        gap_d     = gap_q;
        frames_d  = frames_q;
        gap_cnt_d = gap_cnt_q;
        idx_d     = idx_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_SEND;
                    shift_d  = pattern;
                    pat_d    = pattern;
                    gap_d    = gap;
                    frames_d = repeat_cnt;
                    idx_d    = LAST_IDX;
                end
            end
            S_SEND: begin
                shift_d = {shift_q[PAT_W-2:0], 1'b0};
                idx_d   = idx_q - IDX_W'(1);
                if (idx_q == '0) begin
                    idx_d = LAST_IDX;
                    if (frames_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        // frames_q is nonzero here, so the decrement never wraps
                        frames_d = frames_q - CNT_W'(1);
                        shift_d  = pat_q;
                        if (gap_q != '0) begin
                            state_d   = S_GAP;
                            gap_cnt_d = gap_q;
                        end
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_q == CNT_W'(1)) state_d = S_SEND;
                else                        gap_cnt_d = gap_cnt_q - CNT_W'(1);
            end
            default: state_d = S_IDLE;
        endcase
`ifdef SEQGEN_ABORT_EN
        aborted_d = 1'b0;
        if (abort && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            aborted_d = 1'b1;
        end
`endif
    end

    // Outputs decoded purely from registered state
    always_comb begin
        ready       = (state_q == S_IDLE);
        out_valid   = (state_q == S_SEND);
        out         = out_valid ? shift_q[PAT_W-1] : IDLE_BIT;
        frame_start = out_valid && (idx_q == LAST_IDX);
        done        = out_valid && (idx_q == '0) && (frames_q == '0);
`ifdef SEQGEN_ABORT_EN
        aborted     = aborted_q;
`endif
    end

endmodule

// File: tb/tb_sequence_generator.sv
// tb_sequence_generator: per-cycle expected streams built from frame/gap rules, random runs.
module tb_sequence_generator;
    localparam int PAT_W = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [PAT_W-1:0] pattern = '0;
    logic [CNT_W-1:0] repeat_cnt = '0;
    logic [CNT_W-1:0] gap = '0;
    logic             ready, out, out_valid, frame_start, done;
`ifdef SEQGEN_ABORT_EN
    logic             abort = 1'b0;
    logic             aborted;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [4:0] exp_q[$];

    always #5 clk = ~clk;

    sequence_generator #(.PAT_W(PAT_W), .CNT_W(CNT_W), .IDLE_BIT(1'b0)) dut (
        .clk(clk), .reset(reset),
`ifdef SEQGEN_ABORT_EN
        .abort(abort), .aborted(aborted),
`endif
        .start(start), .pattern(pattern), .repeat_cnt(repeat_cnt), .gap(gap),
        .ready(ready), .out(out), .out_valid(out_valid),
        .frame_start(frame_start), .done(done)
    );

    // observed vector: {ready, out_valid, out, frame_start, done}
    wire [4:0] obs = {ready, out_valid, out, frame_start, done};
    localparam logic [4:0] IDLE_V = 5'b10000;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    // Expected per-cycle stream for one run: frames of bits, gaps between frames
    task automatic build_exp(input logic [PAT_W-1:0] pat, input int rpt, input int gp);
        exp_q.delete();
        for (int f = 0; f <= rpt; f++) begin
            for (int b = PAT_W - 1; b >= 0; b--)
                exp_q.push_back({1'b0, 1'b1, pat[b], (b == PAT_W - 1), (f == rpt && b == 0)});
            if (f < rpt)
                for (int g = 0; g < gp; g++) exp_q.push_back(5'b00000);
        end
    endtask

    task automatic issue(input logic [PAT_W-1:0] pat, input int rpt, input int gp);
        @(negedge clk);
        start = 1'b1; pattern = pat; repeat_cnt = CNT_W'(rpt); gap = CNT_W'(gp);
        @(negedge clk);
        start = 1'b0;
    endtask

    // One full run; optional junk starts while busy must not disturb the stream
    task automatic run_tx(input string tag, input logic [PAT_W-1:0] pat, input int rpt,
                          input int gp, input bit junk);
        build_exp(pat, rpt, gp);
        issue(pat, rpt, gp);
        for (int i = 0; i < exp_q.size(); i++) begin
            chk(tag, obs, exp_q[i]);
            if (junk && $urandom_range(0, 2) == 0) begin
                start = 1'b1; pattern = PAT_W'($urandom);
                repeat_cnt = CNT_W'($urandom); gap = CNT_W'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, "_end"}, obs, IDLE_V);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset", obs, IDLE_V);
        reset = 1'b0;
        @(negedge clk);
        chk("idle", obs, IDLE_V);

        run_tx("t1_single", 4'b1011, 0, 0, 1'b0);
        run_tx("t2_rep2", 4'b1011, 2, 0, 1'b0);
        run_tx("t3_gap2", 4'b1011, 1, 2, 1'b0);

        // busy start with pattern 0000 in the middle of a run
        build_exp(4'b1011, 2, 0);
        issue(4'b1011, 2, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            chk("t4_busy", obs, exp_q[i]);
            start = (i == 5); pattern = '0;
            @(negedge clk);
        end
        start = 1'b0;
        chk("t4_end", obs, IDLE_V);

        // reset during bit 3 of a frame
        build_exp(4'b1101, 1, 1);
        issue(4'b1101, 1, 1);
        for (int i = 0; i < 3; i++) begin
            chk("t5_pre", obs, exp_q[i]);
            if (i == 2) reset = 1'b1;
            @(negedge clk);
        end
        chk("t5_rst", obs, IDLE_V);
        reset = 1'b0;
        run_tx("t5_after", 4'b0110, 1, 1, 1'b0);

`ifdef SEQGEN_ABORT_EN
        // abort during the gap of the test-3 run
        build_exp(4'b1011, 1, 2);
        issue(4'b1011, 1, 2);
        for (int i = 0; i < 5; i++) begin
            chk("t6_pre", obs, exp_q[i]);
            if (i == 4) abort = 1'b1;
            @(negedge clk);
        end
        abort = 1'b0;
        chk("t6_idle", obs, IDLE_V);
        chk("t6_aborted", aborted, 1);
        @(negedge clk);
        chk("t6_pulse", aborted, 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t6_idle_abort", {aborted, obs}, {1'b0, IDLE_V});
`endif

        // boundary: maximum repeat count sends 2^CNT_W frames
        run_tx("max_rep", 4'b1001, (1 << CNT_W) - 1, 0, 1'b0);
        run_tx("max_rep_gap", 4'b0100, (1 << CNT_W) - 1, 1, 1'b1);

        for (int n = 0; n < 40; n++)
            run_tx("rand", PAT_W'($urandom), $urandom_range(0, 4), $urandom_range(0, 3), 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
